// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: h:m:s timebase with N_ALARM editable alarm slots, ring timeout and display/LED drive.
// Define MULTI_ALARM_SNOOZE_EN to make val_add while ringing arm a SNOOZE_M-minute re-ring.
module multi_alarm_ctrl #(
  parameter int MAX_H    = 24,
  parameter int MAX_M    = 60,
  parameter int MAX_S    = 60,
  parameter int N_ALARM  = 4,
  parameter int IDX_W    = $clog2(N_ALARM),
  parameter int TICK_DIV = 1,
  parameter int RING_S   = 60,
  parameter int SNOOZE_M = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               mod_choose,
  input  logic               bit_choose,
  input  logic               val_add,
  input  logic               val_sub,
  input  logic               val_set,
  input  logic               clear,
  output logic [5:0]         out_h,
  output logic [5:0]         out_m,
  output logic [5:0]         out_s,
  output logic [1:0]         mode,
  output logic [IDX_W-1:0]   slot,
  output logic [N_ALARM-1:0] alarm_mask,
  output logic               alarming,
  output logic [3:0]         led
);
  localparam logic [1:0] SHOW = 2'd0, CLK_SET = 2'd1, ALM_SET = 2'd2;
  localparam logic [5:0] H_TOP = 6'(MAX_H - 1), M_TOP = 6'(MAX_M - 1), S_TOP = 6'(MAX_S - 1);
  localparam logic [IDX_W-1:0] SL_TOP = IDX_W'(N_ALARM - 1);
  localparam logic [IDX_W-1:0] SL_ONE = IDX_W'(1);

  logic [31:0]        div_q, div_d, rcnt_q, rcnt_d;
  logic [5:0]         h_q, h_d, m_q, m_d, s_q, s_d, th_q, th_d, tm_q, tm_d;
  logic [5:0]         ah_q [N_ALARM];
  logic [5:0]         ah_d [N_ALARM];
  logic [5:0]         am_q [N_ALARM];
  logic [5:0]         am_d [N_ALARM];
  logic [1:0]         mode_q, mode_d, field_q, field_d;
  logic [IDX_W-1:0]   slot_q, slot_d;
  logic [N_ALARM-1:0] mask_q, mask_d;
  logic               ring_q, ring_d, tick, roll, hit;
  logic [5:0]         oh_q, oh_d, om_q, om_d, os_q, os_d;
  logic [3:0]         led_q, led_d;
`ifdef MULTI_ALARM_SNOOZE_EN
  logic               snz_q, snz_d;
  logic [5:0]         sh_q, sh_d, sm_q, sm_d;
  logic [6:0]         msum;
`endif

  always_comb begin
    div_d = div_q; rcnt_d = rcnt_q; h_d = h_q; m_d = m_q; s_d = s_q; th_d = th_q; tm_d = tm_q;
    ah_d = ah_q; am_d = am_q; mode_d = mode_q; field_d = field_q; slot_d = slot_q;
    mask_d = mask_q; ring_d = ring_q; hit = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
    snz_d = snz_q; sh_d = sh_q; sm_d = sm_q;
`endif
    tick = div_q == 32'(TICK_DIV - 1);
    roll = tick && s_q == S_TOP;
    div_d = tick ? '0 : div_q + 32'd1;
    if (tick) begin
      s_d = s_q == S_TOP ? '0 : s_q + 6'd1;
      m_d = s_q != S_TOP ? m_q : m_q == M_TOP ? '0 : m_q + 6'd1;
      h_d = (s_q != S_TOP || m_q != M_TOP) ? h_q : h_q == H_TOP ? '0 : h_q + 6'd1;
    end
    if (ring_q && tick) begin
      rcnt_d = rcnt_q + 32'd1;
      if (rcnt_d == 32'(RING_S)) ring_d = 1'b0;
    end
    if (!en) begin
      mode_d = SHOW; field_d = '0; ring_d = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_d = 1'b0;
`endif
    end else if (mod_choose) begin
      mode_d = mode_q == ALM_SET ? SHOW : mode_q + 2'd1;
      field_d = '0;
      th_d = mode_q == SHOW ? h_q : ah_q[slot_q];
      tm_d = mode_q == SHOW ? m_q : am_q[slot_q];
    end else if (clear) begin
      ring_d = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_d = 1'b0;
`endif
      if (!ring_q && mode_q == ALM_SET) mask_d[slot_q] = 1'b0;
    end else if (ring_q) begin
`ifdef MULTI_ALARM_SNOOZE_EN
      if (val_add) begin ring_d = 1'b0; snz_d = 1'b1; end
`endif
    end else if (mode_q != SHOW) begin
      if (val_set) begin
        if (mode_q == CLK_SET) begin
          h_d = th_q; m_d = tm_q; s_d = '0; div_d = '0; roll = 1'b0;
        end else begin
          ah_d[slot_q] = th_q; am_d[slot_q] = tm_q; mask_d[slot_q] = 1'b1;
        end
      end else if (val_add || val_sub) begin
        if (field_q == 2'd0)
          tm_d = val_add ? (tm_q == M_TOP ? '0 : tm_q + 6'd1) : (tm_q == '0 ? M_TOP : tm_q - 6'd1);
        else if (field_q == 2'd1)
          th_d = val_add ? (th_q == H_TOP ? '0 : th_q + 6'd1) : (th_q == '0 ? H_TOP : th_q - 6'd1);
        else begin
          slot_d = val_add ? (slot_q == SL_TOP ? '0 : slot_q + SL_ONE) : (slot_q == '0 ? SL_TOP : slot_q - SL_ONE);
          th_d = ah_q[slot_d];
          tm_d = am_q[slot_d];
        end
      end else if (bit_choose)
        field_d = (field_q == 2'd2 || (field_q == 2'd1 && mode_q == CLK_SET)) ? 2'd0 : field_q + 2'd1;
    end
    // A clock-set write discards the coincident tick, so it cannot trigger a match.
    if (en && roll && !ring_q) begin
      for (int i = 0; i < N_ALARM; i++)
        if (mask_q[i] && ah_q[i] == h_d && am_q[i] == m_d) hit = 1'b1;
`ifdef MULTI_ALARM_SNOOZE_EN
      if (snz_d && sh_q == h_d && sm_q == m_d) begin hit = 1'b1; snz_d = 1'b0; end
`endif
      if (hit) begin ring_d = 1'b1; rcnt_d = '0; end
    end
`ifdef MULTI_ALARM_SNOOZE_EN
    msum = {1'b0, m_d} + 7'(SNOOZE_M);
    if (hit) begin
      sm_d = msum > 7'(M_TOP) ? 6'(msum - 7'(MAX_M)) : msum[5:0];
      sh_d = msum <= 7'(M_TOP) ? h_d : h_d == H_TOP ? '0 : h_d + 6'd1;
    end
`endif
    oh_d = mode_d == SHOW ? h_d : th_d;
    om_d = mode_d == SHOW ? m_d : tm_d;
    os_d = mode_d == SHOW ? s_d : mode_d == CLK_SET ? '0 : 6'(slot_d);
    led_d = ring_d ? 4'hF : mode_d == SHOW ? 4'h0 : 4'b0001 << field_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0; rcnt_q <= '0; h_q <= '0; m_q <= '0; s_q <= '0; th_q <= '0; tm_q <= '0;
      ah_q <= '{default: '0}; am_q <= '{default: '0};
      mode_q <= SHOW; field_q <= '0; slot_q <= '0; mask_q <= '0; ring_q <= 1'b0;
      oh_q <= '0; om_q <= '0; os_q <= '0; led_q <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_q <= 1'b0; sh_q <= '0; sm_q <= '0;
`endif
    end else begin
      div_q <= div_d; rcnt_q <= rcnt_d; h_q <= h_d; m_q <= m_d; s_q <= s_d; th_q <= th_d; tm_q <= tm_d;
      ah_q <= ah_d; am_q <= am_d;
      mode_q <= mode_d; field_q <= field_d; slot_q <= slot_d; mask_q <= mask_d; ring_q <= ring_d;
      oh_q <= oh_d; om_q <= om_d; os_q <= os_d; led_q <= led_d;
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_q <= snz_d; sh_q <= sh_d; sm_q <= sm_d;
`endif
    end
  end

  assign out_h = oh_q;
  assign out_m = om_q;
  assign out_s = os_q;
  assign mode = mode_q;
  assign slot = slot_q;
  assign alarm_mask = mask_q;
  assign alarming = ring_q;
  assign led = led_q;
endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb_multi_alarm_ctrl: directed checks of timebase, clock/alarm editing, ringing, timeout, en and snooze.
module tb_multi_alarm_ctrl;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic mod_choose = 1'b0, bit_choose = 1'b0, val_add = 1'b0, val_sub = 1'b0, val_set = 1'b0, clear = 1'b0;
  logic [5:0] out_h, out_m, out_s;
  logic [1:0] mode, slot;
  logic [3:0] alarm_mask, led;
  logic alarming;
  int checks = 0, errors = 0, t = 0;
  localparam int MC = 32, BC = 16, VA = 8, VS = 4, SET = 2, CL = 1;

  multi_alarm_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .mod_choose(mod_choose), .bit_choose(bit_choose),
    .val_add(val_add), .val_sub(val_sub), .val_set(val_set), .clear(clear),
    .out_h(out_h), .out_m(out_m), .out_s(out_s), .mode(mode), .slot(slot),
    .alarm_mask(alarm_mask), .alarming(alarming), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // t models live seconds since midnight; every edge is a tick with TICK_DIV=1.
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); t = (t + 1) % 86400; end
    #1;
  endtask

  task automatic press(input int b, input int n = 1);
    repeat (n) begin
      {mod_choose, bit_choose, val_add, val_sub, val_set, clear} = 6'(b);
      step(1);
      {mod_choose, bit_choose, val_add, val_sub, val_set, clear} = '0;
    end
  endtask

  task automatic run_to(input int target);
    step((target - t + 86400) % 86400);
  endtask

  task automatic check_time(input string tag);
    check({tag, ".h"}, int'(out_h), t / 3600);
    check({tag, ".m"}, int'(out_m), (t / 60) % 60);
    check({tag, ".s"}, int'(out_s), t % 60);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_h", int'(out_h), 0); check("rst_m", int'(out_m), 0); check("rst_s", int'(out_s), 0);
    check("rst_mode", int'(mode), 0); check("rst_slot", int'(slot), 0);
    check("rst_mask", int'(alarm_mask), 0); check("rst_alarming", int'(alarming), 0); check("rst_led", int'(led), 0);
    @(posedge clk); #1;
    reset = 1'b1; en = 1'b1; t = 0;
    step(1);
    check_time("first_tick");
    step(86398);
    check_time("pre_wrap");
    step(1);
    check_time("day_wrap");
    check("day_wrap_h0", int'(out_h), 0);

    press(MC);
    check("clk_mode", int'(mode), 1); check("clk_led", int'(led), 1);
    check("clk_temp_h", int'(out_h), 0); check("clk_temp_s", int'(out_s), 0);
    press(BC);
    check("clk_led_hour", int'(led), 2);
    press(VS);
    check("clk_hour_sub_wrap", int'(out_h), 23);
    press(SET); t = 23 * 3600;
    check("clk_set_h", int'(out_h), 23); check("clk_set_m", int'(out_m), 0);
    check("clk_set_s", int'(out_s), 0); check("clk_set_mode", int'(mode), 1);
    press(MC);
    check("alm_mode", int'(mode), 2); check("alm_slot_disp", int'(out_s), 0);
    press(MC);
    check("show_mode", int'(mode), 0);
    check_time("after_set");

    press(MC); press(BC); press(VA);
    press(SET); t = 0;
    press(MC);
    press(BC, 2); press(VA, 2);
    check("slot_sel", int'(slot), 2); check("slot_disp", int'(out_s), 2); check("led_slot", int'(led), 4);
    press(BC); press(VA, 2);
    check("alm_temp_m", int'(out_m), 2); check("alm_temp_h", int'(out_h), 0);
    press(SET);
    check("mask_slot2", int'(alarm_mask), 4);
    press(MC);
    run_to(119);
    check("pre_ring", int'(alarming), 0);
    step(1);
    check("ring_0002", int'(alarming), 1); check("ring_led", int'(led), 15);
    check_time("ring_time");
    press(CL);
    check("clear_ring", int'(alarming), 0); check("clear_led", int'(led), 0);

    press(MC); press(VS, 2);
    press(SET); t = 0;
    press(MC);
    press(CL);
    check("mask_cleared", int'(alarm_mask), 0);
    press(BC, 2); press(VS);
    check("slot_sub", int'(slot), 1);
    press(BC); press(VA); press(SET);
    check("mask_slot1", int'(alarm_mask), 2);
    press(BC, 2); press(VA, 2);
    check("slot_3", int'(slot), 3);
    press(BC); press(VA); press(SET);
    check("mask_1_3", int'(alarm_mask), 10);
    press(MC);
    run_to(59);
    check("dual_pre", int'(alarming), 0);
    step(1);
    check("dual_ring", int'(alarming), 1);
    run_to(119);
    check("ring_last_tick", int'(alarming), 1);
    step(1);
    check("ring_timeout", int'(alarming), 0);

    press(MC); press(VS, 2);
    press(SET); t = 0;
    press(MC); press(MC);
    run_to(60);
    check("ring_again", int'(alarming), 1);
`ifndef MULTI_ALARM_SNOOZE_EN
    press(VA);
    check("va_ignored_ring", int'(alarming), 1);
`endif
    press(MC);
    check("ring_mc_mode", int'(mode), 1); check("ring_mc_alarming", int'(alarming), 1);
    check("ring_mc_led", int'(led), 15); check("ring_temp_m", int'(out_m), 1);
    press(VS);
    check("ring_vs_ignored", int'(out_m), 1);
    en = 1'b0;
    step(1);
    check("en_low_alarming", int'(alarming), 0); check("en_low_mode", int'(mode), 0);
    check("en_low_led", int'(led), 0);
    en = 1'b1;
    press(MC); press(BC); press(VA);
    check("pre_combo_h", int'(out_h), 1);
    press(MC + SET);
    check("combo_mode", int'(mode), 2);
    press(MC);
    check_time("combo_time_kept");

    press(MC);
    reset = 1'b0;
    #1;
    check("midreset_mode", int'(mode), 0); check("midreset_mask", int'(alarm_mask), 0);
    check("midreset_h", int'(out_h), 0); check("midreset_led", int'(led), 0);
    @(posedge clk); #1;
    reset = 1'b1; t = 0;

`ifdef MULTI_ALARM_SNOOZE_EN
    press(MC, 2); press(VA, 2); press(SET);
    check("snz_mask", int'(alarm_mask), 1);
    press(MC);
    run_to(120);
    check("snz_ring", int'(alarming), 1);
    press(VA);
    check("snz_stop", int'(alarming), 0);
    run_to(419);
    check("snz_pre", int'(alarming), 0);
    step(1);
    check("snz_rering", int'(alarming), 1);
    check_time("snz_time");
    press(CL);
    press(MC); press(BC); press(VS); press(BC); press(VS, 10);
    press(SET); t = 23 * 3600 + 57 * 60;
    press(MC); press(BC); press(VS); press(BC, 2); press(VS, 4); press(SET); press(MC);
    run_to(23 * 3600 + 58 * 60);
    check("snz_late_ring", int'(alarming), 1);
    press(VA);
    check("snz_late_stop", int'(alarming), 0);
    run_to(179);
    check("snz_wrap_pre", int'(alarming), 0);
    step(1);
    check("snz_wrap_ring", int'(alarming), 1);
    check_time("snz_wrap_time");
`else
    step(2);
    check_time("post_reset_time");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_alarm_ctrl.md
# multi_alarm_ctrl

Parametrised successor to the single-alarm clock controller: keeps its own h:m:s timebase from a clock-cycle divider, holds N_ALARM independently editable alarm slots, and rings with optional snooze and auto-timeout. Sits between the debounced button pulses and the 7-segment display mux, driving the display h/m/s buses and the field LEDs directly.

## Interface
- MAX_H, 24, hour modulus (hours 0..MAX_H-1)
- MAX_M, 60, minute modulus
- MAX_S, 60, second modulus
- N_ALARM, 4, alarm slot count (2..8); IDX_W = $clog2(N_ALARM)
- TICK_DIV, 1, clk cycles per second (1 = every cycle is a tick)
- RING_S, 60, seconds of ringing before auto-dismiss
- SNOOZE_M, 5, snooze offset in minutes (< MAX_M)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  enable; low forces SHOW mode, cancels ringing
- mod_choose, bit_choose, val_add, val_sub, val_set, clear  in  1 each  single-cycle button pulses
- out_h, out_m, out_s  out  6 each  display value
- mode  out  2  0 SHOW, 1 CLK_SET, 2 ALM_SET
- slot  out  IDX_W  currently selected alarm slot
- alarm_mask  out  N_ALARM  per-slot enable bits
- alarming  out  1  ringing
- led  out  4  one-hot edit field / all ones while ringing

## Operation
- Timebase: divider 0..TICK_DIV-1; tick when divider = TICK_DIV-1. On tick s increments; s wrap carries to m, m wrap carries to h, h wraps MAX_H-1 -> 0. Time runs regardless of en and mode.
- Mode FSM: mod_choose steps SHOW -> CLK_SET -> ALM_SET -> SHOW. Entering CLK_SET loads temp from live h:m; entering ALM_SET loads temp from slot `slot`. Leaving a set mode without val_set discards temp. field resets to 0 on any mode change.
- field (2 bits): bit_choose cycles 0 minute, 1 hour, 2 slot (ALM_SET only; in CLK_SET wraps 1 -> 0).
- val_add/val_sub: minute/hour field wraps modulo MAX_M/MAX_H in both directions. Slot field: slot +/-1 modulo N_ALARM, temp reloaded from new slot.
- val_set: CLK_SET -> time := temp h:m, s := 0, divider := 0, mode stays. ALM_SET -> slot := temp, alarm_mask[slot] := 1.
- clear in ALM_SET (not ringing): alarm_mask[slot] := 0.
- Match: on the tick producing s = 0, if not ringing and any enabled slot equals new h:m, ring; lowest index wins. Matches while ringing ignored.
- Ringing: alarming = 1, ring counter counts ticks; clear dismisses; counter reaching RING_S dismisses. While ringing all buttons except clear (and val_add, see Configuration) and mod_choose are ignored; mod_choose still works.
- Display: SHOW -> live h:m:s; CLK_SET -> temp h:m, out_s = 0; ALM_SET -> temp h:m, out_s = zero-extended slot.
- en low: mode := SHOW, field := 0, ringing/snooze cancelled, matching suppressed; slots and time retained.

## Timing
- All outputs registered; reset values: out_* = 0, mode = 0, slot = 0, alarm_mask = 0, alarming = 0, led = 0; time = 00:00:00, all slots 00:00.
- Button pulse -> visible output change 1 cycle later.
- Match tick -> alarming high the following cycle.
- Priority in one cycle: reset > !en > mod_choose > clear > val_set > val_add > val_sub > bit_choose. CLK_SET val_set wins over a coincident tick (tick discarded).
- Reset mid-ring or mid-edit returns everything to reset values.

## Configuration
- MULTI_ALARM_SNOOZE_EN defined: val_add while ringing stops ringing and arms snooze target = ring time + SNOOZE_M minutes (minute carry into hour, hour wraps MAX_H); re-rings at s = 0 tick on target; snooze cleared by clear, en low, or re-ring. Snooze ring ignores alarm_mask.
- Undefined: no snooze registers; val_add while ringing is ignored.

## Test plan
- TICK_DIV=1, run 86400 cycles from reset -> time returns 00:00:00; 23:59:59 -> 00:00:00 wraps.
- CLK_SET: field hour, val_sub at 00 -> 23; val_set -> out 23:mm:00, divider restarted.
- ALM_SET slot 2 := 00:02, val_set -> alarm_mask = 4'b0100; at 00:02:00 tick alarming = 1 next cycle, clear -> 0.
- Slots 1 and 3 both 00:01 -> ring once, ring counter auto-dismisses after exactly 60 ticks.
- SNOOZE_EN: ring at 00:02, val_add -> alarming 0, re-ring at 00:07:00; ring at 23:58 snoozes to 00:03.
- en low while ringing -> alarming 0, mode 0 next cycle; mod_choose + val_set same cycle -> only mode changes.
